// File: rtl/mrd_pkg.sv
// Shared types and constants for the mixed-radix DFT streaming bridge.
// Holds the framing FSM state encoding and default geometry.
package mrd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DROP
    } state_t;

    localparam int MIN_PTS    = 12;
    localparam int DEF_DW     = 18;
    localparam int DEF_PW     = 12;
    localparam int DEF_MAXPTS = 1200;

endpackage

// File: rtl/mrd_skid_buf.sv
// Two-entry skid buffer with a registered upstream ready.
// Ports: in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
// (downstream), clk, async active-low rst_n. Width set by W.
module mrd_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   count;
    logic [1:0]   count_nx;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = head;

    always_comb begin
        count_nx = count + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            in_ready <= 1'b0;
            head     <= '0;
            tail     <= '0;
        end else begin
            count    <= count_nx;
            // ready for next cycle only if a slot survives this cycle
            in_ready <= (count_nx != 2'd2);
            if (push && !pop) begin
                if (count == 2'd0) begin
                    head <= in_data;
                end else begin
                    tail <= in_data;
                end
            end else if (!push && pop) begin
                head <= tail;
            end else if (push && pop) begin
                if (count == 2'd1) begin
                    head <= in_data;
                end else begin
                    head <= tail;
                    tail <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/mrd_st_bridge.sv
// Streaming framing bridge: validates sop/eop framing against dftpts,
// stamps each forwarded beat with frame length, inverse flag and index.
// Ports: sink_* (upstream beats, dftpts_in, inverse), source_* (framed
// beats out), err_pulse (one-cycle framing error), err_count (saturating).
module mrd_st_bridge
    import mrd_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int PW     = DEF_PW,
    parameter int MAXPTS = DEF_MAXPTS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sink_valid,
    output logic          sink_ready,
    input  logic          sink_sop,
    input  logic          sink_eop,
    input  logic          inverse,
    input  logic [DW-1:0] sink_real,
    input  logic [DW-1:0] sink_imag,
    input  logic [PW-1:0] dftpts_in,
    output logic          source_valid,
    input  logic          source_ready,
    output logic          source_sop,
    output logic          source_eop,
    output logic          source_inverse,
    output logic [DW-1:0] source_real,
    output logic [DW-1:0] source_imag,
    output logic [PW-1:0] source_dftpts,
    output logic [PW-1:0] source_idx,
    output logic          err_pulse,
    output logic [7:0]    err_count
);

    localparam int PLW = 3 + 2 * DW + 2 * PW;

    state_t        state;
    state_t        st_nx;
    logic [PW-1:0] dftpts_q;
    logic          inv_q;
    logic [PW-1:0] idx_q;

    logic          acc;
    logic          legal;
    logic          fwd;
    logic          err;
    logic          last;
    logic          f_sop;
    logic          f_eop;
    logic          f_inv;
    logic [PW-1:0] f_pts;
    logic [PW-1:0] f_idx;
    logic [PW-1:0] idx_inc;
    logic [PLW-1:0] in_pl;
    logic [PLW-1:0] out_pl;

    assign acc     = sink_valid && sink_ready;
    assign legal   = (dftpts_in >= PW'(MIN_PTS)) &&
                     (dftpts_in <= PW'(MAXPTS));
    assign idx_inc = idx_q + PW'(1);

    always_comb begin
        st_nx = state;
        fwd   = 1'b0;
        err   = 1'b0;
        last  = 1'b0;
        f_sop = 1'b0;
        f_eop = 1'b0;
        f_inv = inv_q;
        f_pts = dftpts_q;
        f_idx = '0;
        if (acc) begin
            unique case (state)
                ST_IDLE: begin
                    // a lone sop+eop beat is a frame shorter than MIN_PTS
                    if (sink_sop && legal && !sink_eop) begin
                        fwd   = 1'b1;
                        f_sop = 1'b1;
                        f_pts = dftpts_in;
                        f_inv = inverse;
                        st_nx = ST_RUN;
                    end else if (sink_sop) begin
                        err   = 1'b1;
                        st_nx = ST_DROP;
                    end else begin
                        err = 1'b1;
                    end
                end
                ST_RUN: begin
                    fwd   = 1'b1;
                    f_idx = idx_inc;
                    last  = (idx_inc == dftpts_q - PW'(1));
                    f_eop = last || sink_eop;
                    // any combination of faults yields one pulse
                    err   = sink_sop || (last != sink_eop);
                    if (sink_eop) begin
                        st_nx = ST_IDLE;
                    end else if (last) begin
                        st_nx = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (sink_eop) begin
                        st_nx = ST_IDLE;
                    end
                end
                default: st_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dftpts_q  <= '0;
            inv_q     <= 1'b0;
            idx_q     <= '0;
            err_pulse <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state     <= st_nx;
            err_pulse <= err;
            if (err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (fwd) begin
                idx_q    <= f_idx;
                dftpts_q <= f_pts;
                inv_q    <= f_inv;
            end
        end
    end

    assign in_pl = {f_sop, f_eop, f_inv, sink_real, sink_imag, f_pts, f_idx};

    mrd_skid_buf #(
        .W(PLW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (fwd),
        .in_ready (sink_ready),
        .in_data  (in_pl),
        .out_valid(source_valid),
        .out_ready(source_ready),
        .out_data (out_pl)
    );

    assign {source_sop, source_eop, source_inverse, source_real,
            source_imag, source_dftpts, source_idx} = out_pl;

endmodule
